// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Predicts the next PC at fetch; trains from resolved branches and keeps performance counters.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_is_jump,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  correct_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_W      = XLEN - INDEX_BITS - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [INDEX_BITS-1:0] w_fidx;
  logic [TAG_W-1:0]      w_ftag;
  logic                  w_fhit;
  logic [INDEX_BITS-1:0] w_uidx;
  logic [TAG_W-1:0]      w_utag;
  logic                  w_uhit;
  logic                  w_mispredict;

  assign w_fidx = fetch_pc[INDEX_BITS+1:2];
  assign w_ftag = fetch_pc[XLEN-1:INDEX_BITS+2];
  assign w_uidx = upd_pc[INDEX_BITS+1:2];
  assign w_utag = upd_pc[XLEN-1:INDEX_BITS+2];
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  // Fetch-side lookup and resolve-side mispredict detection
  always_comb begin
    pred_taken   = 1'b0;
    pred_target  = fetch_pc + XLEN'(4);
    w_mispredict = 1'b0;
    correct_pc   = upd_pc + XLEN'(4);
    if (w_fhit && (r_jump[w_fidx] || r_ctr[w_fidx][1])) begin
      pred_taken  = 1'b1;
      pred_target = r_target[w_fidx];
    end else begin
      pred_taken  = 1'b0;
    end
    if (upd_taken) begin
      correct_pc = upd_target;
    end else begin
      correct_pc = upd_pc + XLEN'(4);
    end
    if (upd_valid) begin
      w_mispredict = (upd_pred_taken != upd_taken) ||
                     (upd_taken && (upd_pred_target != upd_target));
    end else begin
      w_mispredict = 1'b0;
    end
  end

  assign mispredict       = w_mispredict;
  assign branch_count     = r_branch_cnt;
  assign mispredict_count = r_mispred_cnt;

  // Table training: hits adjust counters, taken misses allocate over the indexed entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
        r_jump[i]   <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_uhit) begin
        if (upd_taken) begin
          r_target[w_uidx] <= upd_target;
          if (r_ctr[w_uidx] != 2'b11) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'b01;
        end else begin
          if (r_ctr[w_uidx] != 2'b00) r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'b01;
        end
        r_jump[w_uidx] <= upd_is_jump;
      end else if (upd_taken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_target;
        r_ctr[w_uidx]    <= 2'b10;
        r_jump[w_uidx]   <= upd_is_jump;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (upd_valid) begin
      if (r_branch_cnt != {CNT_W{1'b1}}) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_mispredict && (r_mispred_cnt != {CNT_W{1'b1}}))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against an array-based reference model.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        pred_taken, pred_taken4;
  logic [31:0] pred_target, pred_target4;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict, mispredict4;
  logic [31:0] correct_pc, correct_pc4;
  logic [15:0] branch_count, mispredict_count;
  logic [3:0]  branch_count4, mispredict_count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jump(upd_is_jump),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .correct_pc(correct_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count));

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken4), .pred_target(pred_target4),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jump(upd_is_jump),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict4), .correct_pc(correct_pc4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4));

  // Reference model: plain arrays indexed by (pc/4) mod 16, tag = pc/64
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_jmp   [16];
  int          m_bc, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> 6));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_jmp[idx_of(pc)] || (m_ctr[idx_of(pc)] >= 2));
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (!upd_valid) return 1'b0;
    if (upd_pred_taken != upd_taken) return 1'b1;
    return upd_taken && (upd_pred_target != upd_target);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_step();
    int i;
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0; m_tag[k] = 32'd0; m_tgt[k] = 32'd0; m_ctr[k] = 1; m_jmp[k] = 1'b0;
      end
      m_bc = 0; m_mc = 0;
    end else if (upd_valid) begin
      i = idx_of(upd_pc);
      m_bc++;
      if (m_mis()) m_mc++;
      if (m_hit(upd_pc)) begin
        m_ctr[i] = upd_taken ? sat(m_ctr[i] + 1, 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (upd_taken) m_tgt[i] = upd_target;
        m_jmp[i] = upd_is_jump;
      end else if (upd_taken) begin
        m_valid[i] = 1'b1; m_tag[i] = upd_pc >> 6; m_tgt[i] = upd_target;
        m_ctr[i] = 2; m_jmp[i] = upd_is_jump;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred_taken(fetch_pc)});
    chk("pred_target", pred_target, m_pred_target(fetch_pc));
    chk("mispredict", {31'd0, mispredict}, {31'd0, m_mis()});
    chk("correct_pc", correct_pc, upd_taken ? upd_target : upd_pc + 32'd4);
    chk("branch_count", {16'd0, branch_count}, sat(m_bc, 65535));
    chk("mispredict_count", {16'd0, mispredict_count}, sat(m_mc, 65535));
    chk("branch_count4", {28'd0, branch_count4}, sat(m_bc, 15));
    chk("mispredict_count4", {28'd0, mispredict_count4}, sat(m_mc, 15));
    chk("pred_target4", pred_target4, m_pred_target(fetch_pc));
  endtask

  task automatic drive(input logic rst, input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic ujmp, input logic uptk,
                       input logic [31:0] uptgt, input logic [31:0] fpc);
    @(negedge clk);
    reset = rst; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_is_jump = ujmp; upd_pred_taken = uptk; upd_pred_target = uptgt; fetch_pc = fpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        ujmp;
    logic        uptk;
    logic [31:0] uptgt;
    logic [31:0] fpc;
    logic        e_ptk;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_cpc;
  } vec_t;

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic ujmp, input logic uptk,
                              input logic [31:0] uptgt, input logic [31:0] fpc,
                              input logic e_ptk, input logic [31:0] e_ptgt,
                              input logic e_mis, input logic [31:0] e_cpc);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.ujmp = ujmp; v.uptk = uptk;
    v.uptgt = uptgt; v.fpc = fpc; v.e_ptk = e_ptk; v.e_ptgt = e_ptgt; v.e_mis = e_mis;
    v.e_cpc = e_cpc;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    logic [31:0] pool [8];
    logic [31:0] upc_r, fpc_r, tgt_r;
    logic        ut_r, ptk_r;

    vecs[0]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h40,  0, 32'h44,  0, 32'h4);
    vecs[1]  = mk(1, 32'h40,  1, 32'h100, 0, 0, 32'h44,  32'h40,  0, 32'h44,  1, 32'h100);
    vecs[2]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h40,  1, 32'h100, 0, 32'h4);
    vecs[3]  = mk(1, 32'h40,  0, 32'h0,   0, 1, 32'h100, 32'h40,  1, 32'h100, 1, 32'h44);
    vecs[4]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h40,  0, 32'h44,  0, 32'h4);
    vecs[5]  = mk(1, 32'h40,  1, 32'h100, 0, 0, 32'h44,  32'h40,  0, 32'h44,  1, 32'h100);
    vecs[6]  = mk(1, 32'h40,  1, 32'h100, 0, 1, 32'h100, 32'h40,  1, 32'h100, 0, 32'h100);
    vecs[7]  = mk(1, 32'h40,  1, 32'h100, 0, 1, 32'h100, 32'h40,  1, 32'h100, 0, 32'h100);
    vecs[8]  = mk(1, 32'h40,  0, 32'h0,   0, 1, 32'h100, 32'h40,  1, 32'h100, 1, 32'h44);
    vecs[9]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h40,  1, 32'h100, 0, 32'h4);
    vecs[10] = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h440, 0, 32'h444, 0, 32'h4);
    vecs[11] = mk(1, 32'h440, 1, 32'h200, 0, 0, 32'h444, 32'h440, 0, 32'h444, 1, 32'h200);
    vecs[12] = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h40,  0, 32'h44,  0, 32'h4);
    vecs[13] = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h440, 1, 32'h200, 0, 32'h4);
    vecs[14] = mk(1, 32'h80,  1, 32'h300, 1, 0, 32'h84,  32'h80,  0, 32'h84,  1, 32'h300);
    vecs[15] = mk(1, 32'h80,  0, 32'h0,   1, 1, 32'h300, 32'h80,  1, 32'h300, 1, 32'h84);
    vecs[16] = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h80,  1, 32'h300, 0, 32'h4);
    vecs[17] = mk(1, 32'h80,  1, 32'h304, 1, 1, 32'h300, 32'h80,  1, 32'h300, 1, 32'h304);
    vecs[18] = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h80,  1, 32'h304, 0, 32'h4);
    vecs[19] = mk(0, 32'hFFFFFFFC, 0, 32'h0, 0, 1, 32'h8, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0);
    vecs[20] = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h82,  1, 32'h304, 0, 32'h4);

    drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h40);
    tick();
    drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h40);
    tick();

    for (int i = 0; i < 21; i++) begin
      drive(0, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].ujmp,
            vecs[i].uptk, vecs[i].uptgt, vecs[i].fpc);
      chk($sformatf("vec%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_ptk});
      chk($sformatf("vec%0d pred_target", i), pred_target, vecs[i].e_ptgt);
      chk($sformatf("vec%0d mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
      chk($sformatf("vec%0d correct_pc", i), correct_pc, vecs[i].e_cpc);
      if (i == 2) begin
        chk("vec2 branch_count", {16'd0, branch_count}, 32'd1);
        chk("vec2 mispredict_count", {16'd0, mispredict_count}, 32'd1);
      end
      check_model();
      tick();
    end

    // Randomized traffic over a small PC pool so entries hit, alias and wrap
    pool[0] = 32'h40; pool[1] = 32'h80; pool[2] = 32'h440; pool[3] = 32'h1000;
    pool[4] = 32'h1004; pool[5] = 32'h1040; pool[6] = 32'hFFFFFFFC; pool[7] = 32'h2043;
    for (int n = 0; n < 400; n++) begin
      upc_r = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 7)];
      fpc_r = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 7)];
      tgt_r = {$urandom_range(0, 3), 2'b00} << 8;
      ut_r  = 1'($urandom_range(0, 1));
      ptk_r = ($urandom_range(0, 3) != 0) ? m_pred_taken(upc_r) : 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0), upc_r, ut_r,
            tgt_r, 1'($urandom_range(0, 4) == 0), ptk_r,
            ($urandom_range(0, 3) != 0) ? m_pred_target(upc_r) : tgt_r, fpc_r);
      check_model();
      tick();
    end

    // Reset with a concurrent taken update: update discarded, mispredict still computed
    drive(0, 1, 32'h40, 1, 32'h100, 0, 0, 32'h44, 32'h40);
    tick();
    drive(1, 1, 32'h40, 1, 32'h100, 0, 0, 32'h44, 32'h40);
    chk("rst mispredict", {31'd0, mispredict}, 32'd1);
    chk("rst correct_pc", correct_pc, 32'h100);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h40);
    chk("post-rst pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("post-rst pred_target", pred_target, 32'h44);
    chk("post-rst branch_count", {16'd0, branch_count}, 32'd0);
    chk("post-rst mispredict_count", {16'd0, mispredict_count}, 32'd0);
    tick();

    // Counter saturation: 20 updates, each mispredicted
    for (int n = 0; n < 20; n++) begin
      drive(0, 1, 32'h1000 + 32'(n * 4), 0, 32'h0, 0, 1, 32'h0, 32'h40);
      tick();
    end
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h40);
    chk("sat branch_count4", {28'd0, branch_count4}, 32'd15);
    chk("sat mispredict_count4", {28'd0, mispredict_count4}, 32'd15);
    chk("sat branch_count16", {16'd0, branch_count}, 32'd20);
    chk("sat mispredict_count16", {16'd0, mispredict_count}, 32'd20);
    check_model();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Sits beside the PC in IF. Given fetch_pc, it returns a predicted next PC in the same cycle.
- The resolving stage feeds back actual branch/jump outcomes. From these the block trains the table, flags mispredicts, supplies the corrected PC for the pipeline flush, and keeps performance counters.
- Replaces static "predict not-taken, resolve in MEM" with prediction at fetch.

Parameters:
- XLEN, 32, data/address width.
- ENTRIES, 16, BTB entries; power of two, ≥2. INDEX_BITS = $clog2(ENTRIES).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_pc  in  XLEN  PC being fetched in IF.
- pred_taken  out  1  prediction for fetch_pc (combinational).
- pred_target  out  XLEN  predicted next PC (combinational).
- upd_valid  in  1  a branch/jump resolved this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual taken target.
- upd_is_jump  in  1  unconditional jump.
- upd_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- upd_pred_target  in  XLEN  predicted target carried down the pipe.
- mispredict  out  1  resolved outcome differs from prediction (combinational).
- correct_pc  out  XLEN  redirect PC when mispredict=1.
- branch_count  out  CNT_W  resolved branches/jumps since reset.
- mispredict_count  out  CNT_W  mispredicts since reset.

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[XLEN-1:INDEX_BITS+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target[XLEN], ctr[1:0], is_jump.
- Lookup (combinational):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && (is_jump || ctr[1]).
  - pred_target = pred_taken ? target : fetch_pc+4.
  - Wrap-around: fetch_pc+4 is modulo 2^XLEN.
- Mispredict (combinational, gated by upd_valid):
  - mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
  - correct_pc = upd_taken ? upd_target : upd_pc+4.
  - Both are valid in the same cycle as upd_valid. mispredict = 0 when upd_valid = 0.
- Update (rising edge, upd_valid=1, reset=0), using upd_pc index/tag:
  - Hit: ctr saturating +1 if taken, -1 if not (bounds 00/11). If taken, target <= upd_target. is_jump <= upd_is_jump.
  - Miss and taken: allocate by overwriting the indexed entry. valid=1, tag, target, ctr=10 (weakly taken), is_jump.
  - Miss and not taken: no table change.
- Timing:
  - Update latency is one cycle: a lookup in the update cycle sees old contents, and the new contents are visible the next cycle.
  - Same-index lookup and update in one cycle is legal; lookup returns pre-update data.
- Counters:
  - branch_count += 1 on each upd_valid.
  - mispredict_count += 1 when mispredict=1.
  - Both saturate at all-ones; no wrap.
- Reset (synchronous, priority over update):
  - All valid <= 0; all ctr <= 01; targets/tags <= 0; both counters <= 0.
  - Resulting outputs: pred_taken=0, pred_target=fetch_pc+4.
  - upd_valid asserted during a reset cycle is discarded: no allocation and no count. Combinational mispredict/correct_pc are still computed from inputs.
- No stall input: lookup is stateless; IF stalls simply hold fetch_pc.

Test Plan (ENTRIES=16):
1. Cold lookup: reset, then fetch_pc=0x40 -> pred_taken=0, pred_target=0x44, both counters 0.
2. Train taken: upd_valid, upd_pc=0x40, taken=1, target=0x100, pred_taken=0.
   - Same cycle: mispredict=1, correct_pc=0x100.
   - Next cycle: fetch_pc=0x40 -> pred_taken=1, pred_target=0x100; branch_count=1, mispredict_count=1.
3. Hysteresis: from step 2, one not-taken update on 0x40 -> ctr=01, pred_taken=0. Then three taken updates -> ctr saturates at 11. One not-taken -> still predicts taken.
4. Aliasing: after step 2, fetch 0x440 (same index, tag differs) -> pred_taken=0. Taken update 0x440 -> 0x200 replaces the entry; then 0x40 misses and 0x440 predicts 0x200.
5. Jump and wrong target: update is_jump=1, pc=0x80, target 0x300, then a not-taken-style ctr decrement -> still predicted taken. Update with pred_target=0x300 but upd_target=0x304 -> mispredict=1, correct_pc=0x304.
6. Reset mid-operation: assert reset with upd_valid=1, pc=0x40, taken -> after the edge, 0x40 misses and counters are 0. Counter saturation: CNT_W=4, 20 updates -> branch_count=15.
